// File: rtl/ram_bist_sequencer_if.sv
// ---------------------------------------------------------------------------
// ram_bist_sequencer_if
// Write/read port bundle between the BIST sequencer and one RAM macro.
//
// Signals:
//   ram_wa_o       write address
//   ram_wd_o       write data
//   ram_wen_o      byte write enables, active high
//   ram_wclk_en_o  write clock enable
//   ram_ra_o       read address
//   ram_rclk_en_o  read clock enable
//   ram_rd_i       read data returned by the RAM
//
// Modports:
//   master  sequencer side (drives address/data/enables, receives read data)
//   slave   RAM side
// ---------------------------------------------------------------------------
interface ram_bist_sequencer_if #(
   parameter int ADDR_W = 9
);
   logic [ADDR_W-1:0] ram_wa_o;
   logic [15:0]       ram_wd_o;
   logic [1:0]        ram_wen_o;
   logic              ram_wclk_en_o;
   logic [ADDR_W-1:0] ram_ra_o;
   logic              ram_rclk_en_o;
   logic [15:0]       ram_rd_i;

   modport master (
      output ram_wa_o,
      output ram_wd_o,
      output ram_wen_o,
      output ram_wclk_en_o,
      output ram_ra_o,
      output ram_rclk_en_o,
      input  ram_rd_i
   );

   modport slave (
      input  ram_wa_o,
      input  ram_wd_o,
      input  ram_wen_o,
      input  ram_wclk_en_o,
      input  ram_ra_o,
      input  ram_rclk_en_o,
      output ram_rd_i
   );
endinterface

// File: rtl/ram_bist_sequencer.sv
// ---------------------------------------------------------------------------
// ram_bist_sequencer
// Deterministic write/read-back test sequencer for one 2^DEPTH_LOG2 x 16 RAM.
// A full-depth write pass with a selectable data pattern is followed by a
// full-depth read pass; every read word is compared against the pattern and
// the run reports pass/fail, error count and first failing address.
//
// Parameters:
//   RD_LAT      RAM read latency in cycles (1 or 2)
//   DEPTH_LOG2  address width
//
// Ports:
//   WBs_CLK_i        sole clock (RAM WClk/RClk share it)
//   WBs_RST_n_i      asynchronous active-low reset
//   start_i          start request, honoured in IDLE only
//   abort_i          terminates a run, wins over start_i
//   pattern_sel_i    0: addr, 1: ~addr, 2: 5555/AAAA checkerboard, 3: seed+addr
//   seed_i           base for pattern 3, latched at start
//   inject_i         (RAM_BIST_ERR_INJECT_EN only) flip bit 0 of the last word
//   ram              RAM port bundle (master modport)
//   busy_o           run in progress
//   done_o           one-cycle completion pulse
//   pass_o           last completed run had zero errors
//   err_cnt_o        mismatches in the current/last run
//   first_err_adr_o  address of the first mismatch, 0 if none
//
// Optional feature macro: RAM_BIST_ERR_INJECT_EN
// ---------------------------------------------------------------------------
module ram_bist_sequencer #(
   parameter int RD_LAT     = 1,
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                    WBs_CLK_i,
   input  logic                    WBs_RST_n_i,
   input  logic                    start_i,
   input  logic                    abort_i,
   input  logic [1:0]              pattern_sel_i,
   input  logic [15:0]             seed_i,
`ifdef RAM_BIST_ERR_INJECT_EN
   input  logic                    inject_i,
`endif
   ram_bist_sequencer_if.master    ram,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    pass_o,
   output logic [DEPTH_LOG2:0]     err_cnt_o,
   output logic [DEPTH_LOG2-1:0]   first_err_adr_o
);

   localparam int                ADR_W    = DEPTH_LOG2;
   localparam logic [ADR_W-1:0]  LAST_ADR = {ADR_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                         state_r;
   logic [ADR_W-1:0]               adr_r;
   logic [1:0]                     drain_cnt_r;
   logic [1:0]                     pat_sel_r;
   logic [15:0]                    seed_r;
`ifdef RAM_BIST_ERR_INJECT_EN
   logic                           inject_r;
`endif

   // Expected-data pipeline aligned to the RAM read latency
   logic [RD_LAT-1:0]              sr_vld_r;
   logic [RD_LAT-1:0][15:0]        sr_exp_r;
   logic [RD_LAT-1:0][ADR_W-1:0]   sr_adr_r;

   logic [1:0]                     sel_s;
   logic [15:0]                    seed_s;
   logic                           inj_flip_s;
   logic [ADR_W-1:0]               adr_nxt_s;
   logic [15:0]                    wd_nxt_s;
   logic                           cmp_err_s;
   logic [DEPTH_LOG2:0]            err_cnt_nxt_s;

   function automatic logic [15:0] pattern_f(input logic [1:0]       sel,
                                             input logic [15:0]      seed,
                                             input logic [ADR_W-1:0] adr);
      logic [15:0] adr_ext;
      adr_ext = 16'(adr);
      case (sel)
         2'd0:    pattern_f = adr_ext;
         2'd1:    pattern_f = ~adr_ext;
         2'd2:    pattern_f = adr[0] ? 16'hAAAA : 16'h5555;
         2'd3:    pattern_f = seed + adr_ext;
         default: pattern_f = adr_ext;
      endcase
   endfunction

   // Next write word: in IDLE the first word is built from the live inputs,
   // since the latched copies only become valid on the start edge
   always_comb begin
      if (state_r == S_IDLE) begin
         sel_s     = pattern_sel_i;
         seed_s    = seed_i;
         adr_nxt_s = '0;
      end else begin
         sel_s     = pat_sel_r;
         seed_s    = seed_r;
         adr_nxt_s = adr_r + ADR_W'(1);
      end
`ifdef RAM_BIST_ERR_INJECT_EN
      if (state_r == S_IDLE) begin
         inj_flip_s = inject_i & (adr_nxt_s == LAST_ADR);
      end else begin
         inj_flip_s = inject_r & (adr_nxt_s == LAST_ADR);
      end
`else
      inj_flip_s = 1'b0;
`endif
      wd_nxt_s = pattern_f(sel_s, seed_s, adr_nxt_s) ^ {15'd0, inj_flip_s};
   end

   // Compare at the pipeline tail and the error count it would produce
   always_comb begin
      if (sr_vld_r[RD_LAT-1] && (ram.ram_rd_i != sr_exp_r[RD_LAT-1])) begin
         cmp_err_s = 1'b1;
      end else begin
         cmp_err_s = 1'b0;
      end
      err_cnt_nxt_s = err_cnt_o + {{DEPTH_LOG2{1'b0}}, cmp_err_s};
   end

   // Sequencer FSM, registered RAM drive, compare pipeline and result registers
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
         state_r           <= S_IDLE;
         adr_r             <= '0;
         drain_cnt_r       <= 2'd0;
         pat_sel_r         <= 2'd0;
         seed_r            <= 16'd0;
`ifdef RAM_BIST_ERR_INJECT_EN
         inject_r          <= 1'b0;
`endif
         sr_vld_r          <= '0;
         sr_exp_r          <= '0;
         sr_adr_r          <= '0;
         ram.ram_wa_o      <= '0;
         ram.ram_wd_o      <= 16'd0;
         ram.ram_wen_o     <= 2'b00;
         ram.ram_wclk_en_o <= 1'b0;
         ram.ram_ra_o      <= '0;
         ram.ram_rclk_en_o <= 1'b0;
         busy_o            <= 1'b0;
         done_o            <= 1'b0;
         pass_o            <= 1'b0;
         err_cnt_o         <= '0;
         first_err_adr_o   <= '0;
      end else if ((state_r != S_IDLE) && abort_i) begin
         // Abort: drop enables, flush in-flight compares, keep partial results
         state_r           <= S_IDLE;
         ram.ram_wen_o     <= 2'b00;
         ram.ram_wclk_en_o <= 1'b0;
         ram.ram_rclk_en_o <= 1'b0;
         busy_o            <= 1'b0;
         done_o            <= 1'b0;
         sr_vld_r          <= '0;
      end else begin
         // Expected word enters the pipeline while its address is on the port
         sr_vld_r[0] <= (state_r == S_READ);
         sr_exp_r[0] <= pattern_f(pat_sel_r, seed_r, adr_r);
         sr_adr_r[0] <= adr_r;
         for (int i = 1; i < RD_LAT; i++) begin
            sr_vld_r[i] <= sr_vld_r[i-1];
            sr_exp_r[i] <= sr_exp_r[i-1];
            sr_adr_r[i] <= sr_adr_r[i-1];
         end

         if (cmp_err_s) begin
            err_cnt_o <= err_cnt_nxt_s;
            if (err_cnt_o == '0) begin
               first_err_adr_o <= sr_adr_r[RD_LAT-1];
            end
         end

         case (state_r)
            S_IDLE: begin
               done_o <= 1'b0;
               if (start_i && !abort_i) begin
                  pat_sel_r         <= pattern_sel_i;
                  seed_r            <= seed_i;
`ifdef RAM_BIST_ERR_INJECT_EN
                  inject_r          <= inject_i;
`endif
                  err_cnt_o         <= '0;
                  first_err_adr_o   <= '0;
                  pass_o            <= 1'b0;
                  adr_r             <= '0;
                  ram.ram_wa_o      <= '0;
                  ram.ram_wd_o      <= wd_nxt_s;
                  ram.ram_wen_o     <= 2'b11;
                  ram.ram_wclk_en_o <= 1'b1;
                  busy_o            <= 1'b1;
                  state_r           <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (adr_r == LAST_ADR) begin
                  adr_r             <= '0;
                  ram.ram_wen_o     <= 2'b00;
                  ram.ram_wclk_en_o <= 1'b0;
                  ram.ram_ra_o      <= '0;
                  ram.ram_rclk_en_o <= 1'b1;
                  state_r           <= S_READ;
               end else begin
                  adr_r        <= adr_nxt_s;
                  ram.ram_wa_o <= adr_nxt_s;
                  ram.ram_wd_o <= wd_nxt_s;
               end
            end
            S_READ: begin
               if (adr_r == LAST_ADR) begin
                  ram.ram_rclk_en_o <= 1'b0;
                  drain_cnt_r       <= 2'(RD_LAT - 1);
                  state_r           <= S_DRAIN;
               end else begin
                  adr_r        <= adr_nxt_s;
                  ram.ram_ra_o <= adr_nxt_s;
               end
            end
            S_DRAIN: begin
               if (drain_cnt_r == 2'd0) begin
                  // The final compare lands on this edge, so judge on the next count
                  done_o  <= 1'b1;
                  pass_o  <= (err_cnt_nxt_s == '0);
                  state_r <= S_DONE;
               end else begin
                  drain_cnt_r <= drain_cnt_r - 2'd1;
               end
            end
            S_DONE: begin
               done_o  <= 1'b0;
               busy_o  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               ram.ram_wen_o     <= 2'b00;
               ram.ram_wclk_en_o <= 1'b0;
               ram.ram_rclk_en_o <= 1'b0;
               busy_o            <= 1'b0;
               done_o            <= 1'b0;
               state_r           <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_bist_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ram_bist_sequencer
// Two sequencer instances (RD_LAT=1 and RD_LAT=2), each with a behavioural
// RAM. Expected write words and run results are queued when a run is started
// and compared as the selected instance produces them.
// ---------------------------------------------------------------------------
module tb_ram_bist_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort, sel, stuck_en, inject;
   logic [1:0]  psel;
   logic [15:0] seed;
   logic        start1, start2;

   always #5 clk = ~clk;

   assign start1 = start & ~sel;
   assign start2 = start & sel;

   ram_bist_sequencer_if #(.ADDR_W(9)) bus1 ();
   ram_bist_sequencer_if #(.ADDR_W(9)) bus2 ();

   logic       busy1, done1, pass1, busy2, done2, pass2;
   logic [9:0] err1, err2;
   logic [8:0] first1, first2;

   ram_bist_sequencer #(.RD_LAT(1), .DEPTH_LOG2(9)) dut1 (
      .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .start_i(start1), .abort_i(abort),
      .pattern_sel_i(psel), .seed_i(seed),
`ifdef RAM_BIST_ERR_INJECT_EN
      .inject_i(inject),
`endif
      .ram(bus1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
      .err_cnt_o(err1), .first_err_adr_o(first1));

   ram_bist_sequencer #(.RD_LAT(2), .DEPTH_LOG2(9)) dut2 (
      .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .start_i(start2), .abort_i(abort),
      .pattern_sel_i(psel), .seed_i(seed),
`ifdef RAM_BIST_ERR_INJECT_EN
      .inject_i(inject),
`endif
      .ram(bus2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
      .err_cnt_o(err2), .first_err_adr_o(first2));

   // RAM models: latency 1 for dut1, latency 2 for dut2, optional bit-7 stuck-at-1
   logic [15:0] mem1 [512];
   logic [15:0] mem2 [512];
   logic [15:0] rd1_r, rd2_a_r, rd2_r;

   function automatic logic [15:0] stuck_f(input logic [15:0] d, input logic [8:0] a);
      return (stuck_en && (a == 9'h020 || a == 9'h1F0)) ? (d | 16'h0080) : d;
   endfunction

   always @(posedge clk) begin
      if (bus1.ram_wclk_en_o && bus1.ram_wen_o == 2'b11) mem1[bus1.ram_wa_o] <= bus1.ram_wd_o;
      if (bus1.ram_rclk_en_o) rd1_r <= stuck_f(mem1[bus1.ram_ra_o], bus1.ram_ra_o);
      if (bus2.ram_wclk_en_o && bus2.ram_wen_o == 2'b11) mem2[bus2.ram_wa_o] <= bus2.ram_wd_o;
      if (bus2.ram_rclk_en_o) rd2_a_r <= stuck_f(mem2[bus2.ram_ra_o], bus2.ram_ra_o);
      rd2_r <= rd2_a_r;
   end

   assign bus1.ram_rd_i = rd1_r;
   assign bus2.ram_rd_i = rd2_r;

   // Outputs of the instance under test
   logic        m_busy, m_done, m_pass, m_wclk_en, m_rclk_en;
   logic [1:0]  m_wen;
   logic [8:0]  m_wa, m_ra, m_first;
   logic [15:0] m_wd;
   logic [9:0]  m_err;
   logic [59:0] m_vec;

   always_comb begin
      if (sel) begin
         m_busy = busy2; m_done = done2; m_pass = pass2; m_err = err2; m_first = first2;
         m_wa = bus2.ram_wa_o; m_wd = bus2.ram_wd_o; m_wen = bus2.ram_wen_o;
         m_wclk_en = bus2.ram_wclk_en_o; m_ra = bus2.ram_ra_o; m_rclk_en = bus2.ram_rclk_en_o;
      end else begin
         m_busy = busy1; m_done = done1; m_pass = pass1; m_err = err1; m_first = first1;
         m_wa = bus1.ram_wa_o; m_wd = bus1.ram_wd_o; m_wen = bus1.ram_wen_o;
         m_wclk_en = bus1.ram_wclk_en_o; m_ra = bus1.ram_ra_o; m_rclk_en = bus1.ram_rclk_en_o;
      end
      m_vec = {m_busy, m_done, m_pass, m_err, m_first, m_wa, m_wd, m_wen, m_wclk_en, m_ra, m_rclk_en};
   end

   typedef struct packed { logic [8:0] adr; logic [15:0] dat; } wr_t;
   typedef struct { int cyc; logic [9:0] err; logic [8:0] first; logic pass; int reads; } res_t;

   wr_t         wq[$];
   res_t        rq[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          edge_cnt = 0;
   int          base_cyc = 0;
   int          rd_cnt   = 0;
   logic [15:0] obs_wd [512];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pat_f(input logic [1:0] p, input logic [15:0] sd, input logic [8:0] a);
      case (p)
         2'd0:    return {7'd0, a};
         2'd1:    return ~{7'd0, a};
         2'd2:    return a[0] ? 16'hAAAA : 16'h5555;
         default: return sd + {7'd0, a};
      endcase
   endfunction

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Monitor: pops the scoreboard as the instance under test writes and completes
   always @(negedge clk) begin
      wr_t  w;
      res_t r;
      if (rst_n) begin
         if (m_wclk_en) begin
            obs_wd[m_wa] = m_wd;
            if (wq.size() == 0) begin
               chk("wr_extra", {63'd0, m_wclk_en}, 64'd0);
            end else begin
               w = wq.pop_front();
               chk("wr_adr", {55'd0, m_wa}, {55'd0, w.adr});
               chk("wr_dat", {48'd0, m_wd}, {48'd0, w.dat});
               chk("wr_wen", {62'd0, m_wen}, 64'd3);
            end
         end
         if (m_rclk_en) rd_cnt++;
         if (m_done) begin
            if (rq.size() == 0) begin
               chk("done_unexp", {63'd0, m_done}, 64'd0);
            end else begin
               r = rq.pop_front();
               chk("done_cyc", 64'(edge_cnt - base_cyc + 1), 64'(r.cyc));
               chk("err_cnt", {54'd0, m_err}, {54'd0, r.err});
               chk("first_adr", {55'd0, m_first}, {55'd0, r.first});
               chk("pass", {63'd0, m_pass}, {63'd0, r.pass});
               chk("rd_cnt", 64'(rd_cnt), 64'(r.reads));
               chk("busy_done", {63'd0, m_busy}, 64'd1);
            end
         end
      end
   end

   // Queue the expected writes/result of a run, then pulse start through edge 0
   task automatic run(input logic s, input logic [1:0] p, input logic [15:0] sd,
                      input logic inj, input logic stk, input logic exp_done);
      res_t        r;
      logic [15:0] w, wexp, rdv;
      @(negedge clk);
      sel = s; psel = p; seed = sd; inject = inj; stuck_en = stk; rd_cnt = 0;
      r.err = 10'd0; r.first = 9'd0;
      for (int a = 0; a < 512; a++) begin
         w    = pat_f(p, sd, 9'(a));
         wexp = w ^ ((inj && a == 511) ? 16'h0001 : 16'h0000);
         wq.push_back('{adr: 9'(a), dat: wexp});
         rdv  = wexp | ((stk && (a == 32 || a == 496)) ? 16'h0080 : 16'h0000);
         if (rdv != w) begin
            if (r.err == 10'd0) r.first = 9'(a);
            r.err = r.err + 10'd1;
         end
      end
      r.pass  = (r.err == 10'd0);
      r.cyc   = s ? 1027 : 1026;
      r.reads = 512;
      if (exp_done) rq.push_back(r);
      start = 1'b1;
      @(posedge clk);
      #1 base_cyc = edge_cnt;
      @(negedge clk);
      start = 1'b0;
      chk("busy_c1", {63'd0, m_busy}, 64'd1);
      chk("wa_c1", {55'd0, m_wa}, 64'd0);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (rq.size() != 0 && n < 1200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_timeout"}, 64'(rq.size()), 64'd0);
      chk({tag, "_wq"}, 64'(wq.size()), 64'd0);
      @(negedge clk);
      chk({tag, "_idle"}, {62'd0, m_busy, m_done}, 64'd0);
   endtask

   task automatic wait_cycle(input int c);
      while (edge_cnt - base_cyc + 1 < c) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0; stuck_en = 1'b0;
      inject = 1'b0; psel = 2'd0; seed = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_dut1", {4'd0, busy1, done1, pass1, err1, first1, bus1.ram_wa_o, bus1.ram_wd_o,
                       bus1.ram_wen_o, bus1.ram_wclk_en_o, bus1.ram_ra_o, bus1.ram_rclk_en_o}, 64'd0);
      chk("rst_dut2", {4'd0, busy2, done2, pass2, err2, first2, bus2.ram_wa_o, bus2.ram_wd_o,
                       bus2.ram_wen_o, bus2.ram_wclk_en_o, bus2.ram_ra_o, bus2.ram_rclk_en_o}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Pattern 0, RD_LAT=1
      run(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
      wait_done("p0");
      chk("p0_adr5", {48'd0, obs_wd[5]}, 64'h0005);

      // Pattern 3 with wrapping seed, RD_LAT=2
      run(1'b1, 2'd3, 16'hFFF0, 1'b0, 1'b0, 1'b1);
      wait_done("p3");
      chk("p3_adr10", {48'd0, obs_wd[16]}, 64'h0000);
      chk("p3_pass", {63'd0, m_pass}, 64'd1);

      // Pattern 2 with bit 7 stuck-at-1 at two addresses
      run(1'b0, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b1);
      wait_done("stk");
      chk("stk_err", {54'd0, m_err}, 64'd2);
      chk("stk_first", {55'd0, m_first}, 64'h020);
      chk("stk_pass", {63'd0, m_pass}, 64'd0);

      // start together with abort in IDLE: nothing starts
      @(negedge clk);
      start = 1'b1; abort = 1'b1; stuck_en = 1'b0;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort", {62'd0, m_busy, m_wclk_en}, 64'd0);

      // Abort during READ; a start pulse mid-run is ignored
      run(1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0);
      wait_cycle(100);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cycle(700);
      abort = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", {63'd0, m_busy}, 64'd0);
      chk("abort_en", {60'd0, m_wclk_en, m_rclk_en, m_wen}, 64'd0);
      chk("abort_done", {63'd0, m_done}, 64'd0);
      @(negedge clk);
      abort = 1'b0;
      repeat (400) @(negedge clk);
      chk("abort_pass", {63'd0, m_pass}, 64'd0);
      chk("abort_err", {54'd0, m_err}, 64'd0);
      chk("abort_wq", 64'(wq.size()), 64'd0);

      // Asynchronous reset mid-WRITE, then a clean run
      run(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
      wait_cycle(200);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid", {4'd0, m_vec}, 64'd0);
      wq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run(1'b0, 2'd3, 16'h1234, 1'b0, 1'b0, 1'b1);
      wait_done("post_rst");

`ifdef RAM_BIST_ERR_INJECT_EN
      run(1'b0, 2'd1, 16'h0000, 1'b1, 1'b0, 1'b1);
      wait_done("inj");
      chk("inj_err", {54'd0, m_err}, 64'd1);
      chk("inj_first", {55'd0, m_first}, 64'h1FF);
      chk("inj_pass", {63'd0, m_pass}, 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
